// File: rtl/display_mode_ctrl.sv
// Display-resource controller: debounced MODE key, WATCH/STOPWATCH/TIMER sequencing
// with a blanking gap, registered 7-segment source mux and a timer-expiry alarm overlay.
module display_mode_ctrl #(
  parameter int unsigned DEB_CYCLES    = 20,
  parameter int unsigned BLANK_CYCLES  = 4,
  parameter int unsigned FLASH_HALF    = 250,
  parameter int unsigned ALARM_TIMEOUT = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       timer_done,
  input  logic       alarm_ack,
  input  logic [7:0] watch_seg_data,
  input  logic [7:0] watch_seg_com,
  input  logic [7:0] sw_seg_data,
  input  logic [7:0] sw_seg_com,
  input  logic [7:0] tmr_seg_data,
  input  logic [7:0] tmr_seg_com,
  output logic [7:0] seg_data,
  output logic [7:0] seg_com,
  output logic [7:0] led,
  output logic [1:0] mode_sel,
  output logic       alarm_active
);

  localparam int unsigned DEB_W   = (DEB_CYCLES    > 1) ? $clog2(DEB_CYCLES)    : 1;
  localparam int unsigned BLANK_W = (BLANK_CYCLES  > 1) ? $clog2(BLANK_CYCLES)  : 1;
  localparam int unsigned FLASH_W = (FLASH_HALF    > 1) ? $clog2(FLASH_HALF)    : 1;
  localparam int unsigned ALARM_W = (ALARM_TIMEOUT > 1) ? $clog2(ALARM_TIMEOUT) : 1;

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_HALF - 1);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_WATCH     = 3'd0,
    ST_STOPWATCH = 3'd1,
    ST_TIMER     = 3'd2,
    ST_BLANK     = 3'd3,
    ST_ALARM     = 3'd4
  } state_t;

  // Debouncer state
  logic [1:0]       sync_q;
  logic             deb_level_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             press_q;

  // FSM state and its next values
  state_t             state_q, state_d;
  logic [1:0]         next_mode_q, next_mode_d;
  logic [1:0]         saved_mode_q, saved_mode_d;
  logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               flash_on_q, flash_on_d;
  logic [ALARM_W-1:0] alarm_cnt_q, alarm_cnt_d;

  // Next values of the registered outputs
  logic [7:0] seg_data_d, seg_com_d, led_d;
  logic [1:0] mode_sel_d;
  logic       alarm_active_d;

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      2'd0:    return ST_WATCH;
      2'd1:    return ST_STOPWATCH;
      default: return ST_TIMER;
    endcase
  endfunction

  function automatic logic [1:0] mode_after(input logic [1:0] m);
    return (m >= 2'd2) ? 2'd0 : m + 2'd1;
  endfunction

  // Synchronise the raw key, accept a level after DEB_CYCLES equal samples, pulse on rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b00;
      deb_level_q <= 1'b0;
      deb_cnt_q   <= '0;
      press_q     <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], mode_btn};
      press_q <= 1'b0;
      if (sync_q[1] == deb_level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_level_q <= sync_q[1];
        deb_cnt_q   <= '0;
        press_q     <= sync_q[1];
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_WATCH;
      next_mode_q  <= 2'd0;
      saved_mode_q <= 2'd0;
      blank_cnt_q  <= '0;
      flash_cnt_q  <= '0;
      flash_on_q   <= 1'b0;
      alarm_cnt_q  <= '0;
      seg_data     <= 8'h00;
      seg_com      <= 8'hFF;
      led          <= 8'h00;
      mode_sel     <= 2'd0;
      alarm_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      next_mode_q  <= next_mode_d;
      saved_mode_q <= saved_mode_d;
      blank_cnt_q  <= blank_cnt_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_on_q   <= flash_on_d;
      alarm_cnt_q  <= alarm_cnt_d;
      seg_data     <= seg_data_d;
      seg_com      <= seg_com_d;
      led          <= led_d;
      mode_sel     <= mode_sel_d;
      alarm_active <= alarm_active_d;
    end
  end

  // Next-state logic (timer_done > alarm_ack > press) and output selection
  always_comb begin
    state_d      = state_q;
    next_mode_d  = next_mode_q;
    saved_mode_d = saved_mode_q;
    blank_cnt_d  = blank_cnt_q;
    flash_cnt_d  = flash_cnt_q;
    flash_on_d   = flash_on_q;
    alarm_cnt_d  = alarm_cnt_q;
    mode_sel_d   = mode_sel;

    case (state_q)
      ST_WATCH, ST_STOPWATCH, ST_TIMER: begin
        if (timer_done) begin
          state_d      = ST_ALARM;
          saved_mode_d = mode_sel;
        end else if (press_q) begin
          state_d     = ST_BLANK;
          next_mode_d = mode_after(mode_sel);
          blank_cnt_d = '0;
        end
      end
      ST_BLANK: begin
        if (timer_done) begin
          state_d      = ST_ALARM;
          saved_mode_d = next_mode_q;
        end else if (blank_cnt_q == BLANK_LAST) begin
          state_d    = mode_state(next_mode_q);
          mode_sel_d = next_mode_q;
        end else begin
          blank_cnt_d = blank_cnt_q + BLANK_W'(1);
        end
      end
      ST_ALARM: begin
        if (flash_cnt_q == FLASH_LAST) begin
          flash_cnt_d = '0;
          flash_on_d  = ~flash_on_q;
        end else begin
          flash_cnt_d = flash_cnt_q + FLASH_W'(1);
        end
        if (timer_done) begin
          alarm_cnt_d = '0;
        end else if (alarm_ack || (alarm_cnt_q == ALARM_LAST)) begin
          state_d    = mode_state(saved_mode_q);
          mode_sel_d = saved_mode_q;
        end else begin
          alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
        end
      end
      default: state_d = ST_WATCH;
    endcase

    // Fresh alarm entry restarts the timeout and the blink with the led lit
    if ((state_d == ST_ALARM) && (state_q != ST_ALARM)) begin
      alarm_cnt_d = '0;
      flash_cnt_d = '0;
      flash_on_d  = 1'b1;
    end

    alarm_active_d = (state_d == ST_ALARM);
    led_d          = ((state_d == ST_ALARM) && flash_on_d) ? 8'hFF : 8'h00;

    case (state_q)
      ST_WATCH:     begin seg_data_d = watch_seg_data; seg_com_d = watch_seg_com; end
      ST_STOPWATCH: begin seg_data_d = sw_seg_data;    seg_com_d = sw_seg_com;    end
      ST_TIMER,
      ST_ALARM:     begin seg_data_d = tmr_seg_data;   seg_com_d = tmr_seg_com;   end
      default:      begin seg_data_d = 8'h00;          seg_com_d = 8'hFF;         end
    endcase
  end

endmodule
